// File: rtl/mul_div_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide controller.
// The master side (pipeline) drives requests and operands; the slave side (controller) returns status and HI/LO.
interface mul_div_if;
    logic        empty;
    logic [2:0]  mul_div;
    logic [1:0]  mt_hi_lo;
    logic [1:0]  mf_hi_lo;
    logic [31:0] rf_A;
    logic [31:0] rf_B;
    logic        busy;
    logic        stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;

    modport master (
        output empty, mul_div, mt_hi_lo, mf_hi_lo, rf_A, rf_B,
        input  busy, stall, hi_out, lo_out, mf_data
    );

    modport slave (
        input  empty, mul_div, mt_hi_lo, mf_hi_lo, rf_A, rf_B,
        output busy, stall, hi_out, lo_out, mf_data
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// HI/LO controller: single-cycle multiply and a 32-step restoring divider with sign fix-up.
// Pipeline flush aborts any operation without touching HI/LO.
module mul_div_ctrl (
    input  logic     clk,
    input  logic     rst_p,
    mul_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;

    logic signed [63:0] mul_a, mul_b, prod;
    logic        [32:0] shifted;
    logic               geq;
    logic        [31:0] diff;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[31]);
    endfunction

    // Low 64 bits of the product are exact for both signednesses once operands are extended to 64 bits.
    assign mul_a = {{32{sgn_q & op_a_q[31]}}, op_a_q};
    assign mul_b = {{32{sgn_q & op_b_q[31]}}, op_b_q};
    assign prod  = mul_a * mul_b;

    // op_a_q doubles as dividend shift-out and quotient shift-in register during DIV.
    assign shifted = {rem_q, op_a_q[31]};
    assign geq     = (shifted >= {1'b0, op_b_q});
    assign diff    = shifted[31:0] - op_b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;

        case (state_q)
            IDLE: begin
                if (!bus.empty) begin
                    if (bus.mt_hi_lo[1]) hi_d = bus.rf_A;
                    if (bus.mt_hi_lo[0]) lo_d = bus.rf_A;
                    if (bus.mul_div[0]) begin
                        op_a_d  = bus.rf_A;
                        op_b_d  = bus.rf_B;
                        sgn_d   = bus.mul_div[2];
                        state_d = MUL;
                    end else if (bus.mul_div[1]) begin
                        sgn_d   = bus.mul_div[2];
                        neg_a_d = bus.mul_div[2] & bus.rf_A[31];
                        neg_b_d = bus.mul_div[2] & bus.rf_B[31];
                        op_a_d  = abs_val(bus.rf_A, bus.mul_div[2]);
                        op_b_d  = abs_val(bus.rf_B, bus.mul_div[2]);
                        rem_d   = 32'd0;
                        cnt_d   = 6'd0;
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                {hi_d, lo_d} = prod;
                state_d      = IDLE;
            end
            DIV: begin
                op_a_d = {op_a_q[30:0], geq};
                rem_d  = geq ? diff : shifted[31:0];
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                // With a zero divisor every step succeeds, so the remainder is |rs| and the fix-up restores rs.
                lo_d    = (op_b_q == 32'd0) ? 32'hFFFF_FFFF : cond_neg(op_a_q, neg_a_q ^ neg_b_q);
                hi_d    = cond_neg(rem_q, neg_a_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.empty) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        op_a_q  <= op_a_d;
        op_b_q  <= op_b_d;
        rem_q   <= rem_d;
        sgn_q   <= sgn_d;
        neg_a_q <= neg_a_d;
        neg_b_q <= neg_b_d;
        if (rst_p) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.stall   = busy_q & ((|bus.mul_div[1:0]) | (|bus.mt_hi_lo) | (|bus.mf_hi_lo));
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;
    assign bus.mf_data = bus.mf_hi_lo[1] ? hi_q : lo_q;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed and randomised checks of mul_div_ctrl with a {HI,LO} scoreboard fed by a reference model.
module tb_mul_div_ctrl;
    logic clk;
    logic rst_p;
    int   checks;
    int   errors;
    logic [63:0] sb[$];

    mul_div_if bus ();

    mul_div_ctrl dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb64;
        logic [31:0] q, r;
        if (op[0]) begin
            if (op[2]) begin
                sa   = $signed(a);
                sb64 = $signed(b);
                return sa * sb64;
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op[2]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] e;
        int n;
        @(negedge clk);
        bus.mul_div = op;
        bus.rf_A    = a;
        bus.rf_B    = b;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.mul_div = 3'b000;
        bus.rf_A    = 32'h0BAD_F00D;
        bus.rf_B    = 32'h0000_0001;
        n = 0;
        while (bus.busy && n < 100) begin
            if (poke && n == 1) begin
                bus.mul_div  = 3'b101;
                bus.mt_hi_lo = 2'b11;
                #1;
                chk("stall_on_request", 32'(bus.stall), 32'd1);
            end
            @(negedge clk);
            bus.mul_div  = 3'b000;
            bus.mt_hi_lo = 2'b00;
            n++;
        end
        chk("busy_cycles", 32'(n), op[0] ? 32'd1 : 32'd33);
        e = sb.pop_front();
        chk("hi_result", bus.hi_out, e[63:32]);
        chk("lo_result", bus.lo_out, e[31:0]);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_p        = 1'b1;
        bus.empty    = 1'b0;
        bus.mul_div  = 3'b001;
        bus.mt_hi_lo = 2'b11;
        bus.mf_hi_lo = 2'b00;
        bus.rf_A     = 32'h1234_5678;
        bus.rf_B     = 32'h0000_0002;

        // Reset overrides a concurrent start and move-to.
        repeat (3) @(negedge clk);
        bus.mul_div  = 3'b000;
        bus.mt_hi_lo = 2'b00;
        bus.mf_hi_lo = 2'b10;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_lo", bus.lo_out, 32'd0);
        chk("rst_mf", bus.mf_data, 32'd0);
        bus.mf_hi_lo = 2'b00;
        rst_p = 1'b0;

        run_op(3'b101, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b010, 32'd100, 32'd0, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'hFFFF_FF9C, 32'd0, 1'b0);
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(3'b010, 32'd1000, 32'd7, 1'b1);
        run_op(3'b101, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Move-to preload, then flush a running divide.
        @(negedge clk);
        bus.mt_hi_lo = 2'b10;
        bus.rf_A     = 32'h0000_AAAA;
        @(negedge clk);
        bus.mt_hi_lo = 2'b01;
        bus.rf_A     = 32'h0000_5555;
        @(negedge clk);
        bus.mt_hi_lo = 2'b00;
        chk("mthi", bus.hi_out, 32'h0000_AAAA);
        chk("mtlo", bus.lo_out, 32'h0000_5555);
        bus.mul_div = 3'b010;
        bus.rf_A    = 32'd50;
        bus.rf_B    = 32'd5;
        @(negedge clk);
        bus.mul_div = 3'b000;
        repeat (4) @(negedge clk);
        bus.mt_hi_lo = 2'b10;
        bus.rf_A     = 32'h0000_1234;
        #1;
        chk("stall_mthi_busy", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.mt_hi_lo = 2'b00;
        chk("mthi_ignored", bus.hi_out, 32'h0000_AAAA);
        repeat (4) @(negedge clk);
        bus.empty = 1'b1;
        @(negedge clk);
        bus.empty = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_hi", bus.hi_out, 32'h0000_AAAA);
        chk("flush_lo", bus.lo_out, 32'h0000_5555);
        @(negedge clk);
        chk("flush_hi_later", bus.hi_out, 32'h0000_AAAA);
        bus.mt_hi_lo = 2'b10;
        bus.rf_A     = 32'h0000_1234;
        @(negedge clk);
        bus.mt_hi_lo = 2'b00;
        chk("mthi_retry_hi", bus.hi_out, 32'h0000_1234);
        chk("mthi_retry_lo", bus.lo_out, 32'h0000_5555);

        // Start and move-to coinciding with a flush are dropped.
        bus.empty    = 1'b1;
        bus.mul_div  = 3'b001;
        bus.mt_hi_lo = 2'b11;
        bus.rf_A     = 32'h0000_FFFF;
        @(negedge clk);
        bus.empty    = 1'b0;
        bus.mul_div  = 3'b000;
        bus.mt_hi_lo = 2'b00;
        chk("empty_start_busy", 32'(bus.busy), 32'd0);
        chk("empty_mt_hi", bus.hi_out, 32'h0000_1234);
        @(negedge clk);
        chk("empty_mt_lo", bus.lo_out, 32'h0000_5555);

        // Move-from is a pure mux.
        bus.mf_hi_lo = 2'b10;
        #1;
        chk("mf_hi", bus.mf_data, 32'h0000_1234);
        chk("mf_idle_stall", 32'(bus.stall), 32'd0);
        bus.mf_hi_lo = 2'b01;
        #1;
        chk("mf_lo", bus.mf_data, 32'h0000_5555);
        bus.mf_hi_lo = 2'b11;
        #1;
        chk("mf_both", bus.mf_data, 32'h0000_1234);
        bus.mf_hi_lo = 2'b00;

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.mul_div = 3'b110;
        bus.rf_A    = 32'hFFFF_FF9C;
        bus.rf_B    = 32'd3;
        @(negedge clk);
        bus.mul_div = 3'b000;
        repeat (19) @(negedge clk);
        chk("div_busy_c20", 32'(bus.busy), 32'd1);
        rst_p = 1'b1;
        @(negedge clk);
        rst_p = 1'b0;
        chk("rst_div_busy", 32'(bus.busy), 32'd0);
        chk("rst_div_hi", bus.hi_out, 32'd0);
        chk("rst_div_lo", bus.lo_out, 32'd0);
        run_op(3'b001, 32'd6, 32'd7, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            case ($urandom_range(3))
                0: op = 3'b001;
                1: op = 3'b101;
                2: op = 3'b010;
                default: op = 3'b110;
            endcase
            a = $urandom;
            b = ($urandom_range(7) == 0) ? 32'd0 : $urandom >> $urandom_range(31);
            run_op(op, a, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 clk  input  1  Single clock; every register updates on its rising edge.
REQ-002 rst_p  input  1  Reset, synchronous and active-high.
REQ-003 empty  input  1  Pipeline flush; aborts any operation in progress.
REQ-004 mul_div  input  3  Start request, one cycle wide. Bit0 = multiply, bit1 = divide, bit2 = signed. Bit0 and bit1 are never both set.
REQ-005 mt_hi_lo  input  2  Move-to request: bit1 writes HI, bit0 writes LO.
REQ-006 mf_hi_lo  input  2  Move-from request: bit1 reads HI, bit0 reads LO.
REQ-007 rf_A  input  32  Operand rs; also the move-to data.
REQ-008 rf_B  input  32  Operand rt.
REQ-009 busy  output  1  High while the controller is in MUL, DIV or FIX.
REQ-010 stall  output  1  Combinational. Equals busy AND (mul_div[1:0]≠0 OR mt_hi_lo≠0 OR mf_hi_lo≠0).
REQ-011 hi_out / lo_out  output  32 each  Current HI and LO register values.
REQ-012 mf_data  output  32  hi_out when mf_hi_lo[1]=1, otherwise lo_out.

Function
REQ-013 The state machine SHALL have four states: IDLE, MUL, DIV, FIX.
REQ-014 A start SHALL be accepted only in IDLE with empty=0. Starts requested while busy SHALL be ignored; the pipeline holds them via stall.
REQ-015 Multiply start SHALL capture rs and rt and go to MUL. MUL SHALL last exactly one cycle, then return to IDLE.
REQ-016 In MUL, {HI,LO} SHALL load the 64-bit product: two's-complement when bit2=1, unsigned when bit2=0.
REQ-017 Divide start SHALL capture |rs| and |rt| (raw values when unsigned), both signs, and the signedness. It SHALL clear the 6-bit iteration counter and the partial remainder, then go to DIV.
REQ-018 DIV SHALL run one restoring-division step per cycle for 32 cycles, producing one quotient bit each cycle, MSB first. On the 32nd step (counter=31) it SHALL go to FIX.
REQ-019 In FIX, for signed operations: the quotient SHALL be negated when sign(rs)≠sign(rt); the remainder SHALL be negated when rs<0. LO<=quotient, HI<=remainder, then go to IDLE.
REQ-020 Divide by zero SHALL raise no exception. FIX SHALL write HI<=rs (original value) and LO<=0xFFFFFFFF for both signed and unsigned.
REQ-021 0x80000000 / 0xFFFFFFFF signed SHALL give LO=0x80000000, HI=0.
REQ-022 Latency, with the start sampled at edge 0:
- multiply: busy high in cycle 1; HI/LO valid from cycle 2.
- divide: busy high in cycles 1–33; HI/LO valid from cycle 34.
REQ-023 Move-to SHALL write only in IDLE with empty=0: HI<=rf_A when bit1=1, LO<=rf_A when bit0=1. A move-to while busy SHALL be ignored.
REQ-024 Move-from SHALL be purely combinational; busy only affects stall.
REQ-025 empty=1 in any state SHALL force IDLE on the next edge. HI/LO SHALL stay unchanged, including when empty coincides with MUL or FIX. A start or move-to in the same cycle as empty SHALL be ignored.
REQ-026 HI/LO SHALL change only in MUL, in FIX, or on an accepted move-to.

Reset
REQ-027 On rst_p=1: state<=IDLE, counter<=0, HI<=0, LO<=0. Reset SHALL override empty, start and move-to.
REQ-028 After reset: busy=0, stall=0, hi_out=lo_out=mf_data=0.
REQ-029 Reset during DIV SHALL abandon the operation; HI/LO read 0 on the following cycle.

Verification
REQ-030 Signed mult rs=0xFFFFFFFE, rt=3 -> busy high 1 cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 Unsigned mult 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 Signed div rs=0xFFFFFFF9 (−7), rt=2 -> busy high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 Unsigned div 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF. Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Unsigned div started, then mthi 0x1234 at cycle 5 -> stall=1 and HI unchanged. empty at cycle 10 -> busy=0 in cycle 11 and HI/LO keep their prior values. Repeat mthi -> HI=0x00001234.
REQ-035 Preload HI/LO nonzero, start div, assert rst_p at cycle 20 -> from cycle 21: busy=0, HI=0, LO=0. Any new start then completes normally.
